// File: rtl/ahbl_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ahbl_arbiter_pkg
// Shared definitions for the AHB-lite N:1 arbiter.
//   htrans_e    : AHB transfer-type encodings (IDLE/BUSY/NONSEQ/SEQ)
//   ap_ctrl_t   : fixed-width control part of one address phase
//   AP_CTRL_W   : width of ap_ctrl_t
// The variable-width fields (haddr, d_pc, hartid) are concatenated on top of
// ap_ctrl_t inside the arbiter so a whole address phase can travel through
// one generic one-hot mux.
// ---------------------------------------------------------------------------
package ahbl_arbiter_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef struct packed {
    logic       hwrite;
    logic [1:0] htrans;
    logic [2:0] hsize;
    logic [2:0] hburst;
    logic [3:0] hprot;
    logic       hmastlock;
    logic       hexcl;
    logic [7:0] hmaster;
  } ap_ctrl_t;

  localparam int AP_CTRL_W = $bits(ap_ctrl_t);

endpackage

// File: rtl/ahbl_arbiter_onehot_mux.sv
// ---------------------------------------------------------------------------
// ahbl_arbiter_onehot_mux
// Generic AND-OR multiplexer with a one-hot select. An all-zero select
// yields an all-zero output.
//   sel      in  N     one-hot select
//   data_in  in  N*W   packed inputs, input i at slice i
//   data_out out W     selected input
// ---------------------------------------------------------------------------
module ahbl_arbiter_onehot_mux #(
  parameter int N = 2,
  parameter int W = 32
) (
  input  logic [N-1:0]   sel,
  input  logic [N*W-1:0] data_in,
  output logic [W-1:0]   data_out
);

  always_comb begin
    data_out = '0;
    for (int i = 0; i < N; i++) begin
      data_out = data_out | (data_in[i*W +: W] & {W{sel[i]}});
    end
  end

endmodule

// File: rtl/ahbl_arbiter.sv
// ---------------------------------------------------------------------------
// ahbl_arbiter
// AHB-lite N:1 arbiter. Merges N_PORTS upstream masters onto one downstream
// slave port with fixed priority (lowest index wins). A master that loses
// arbitration, or that requests while the slave is stalling, has its address
// phase captured in a per-port buffer and is stalled until the buffer is
// replayed. Locked transfers keep the bus on their port until that port
// issues an unlocked transfer or goes idle.
//
// Ports (per-master buses packed, port i at slice i):
//   clk, rst                      clock, async active-high reset
//   src_hready                    per-master hready (tie to src_hready_resp)
//   src_hready_resp/hresp/hexokay per-master responses
//   src_haddr .. src_hartid       per-master address phase and sidebands
//   src_hwdata                    per-master write data
//   src_hrdata                    read data, broadcast to all masters
//   dst_*                         single downstream slave port
// ---------------------------------------------------------------------------
module ahbl_arbiter
  import ahbl_arbiter_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        src_hready,
  output logic [N_PORTS-1:0]        src_hready_resp,
  output logic [N_PORTS-1:0]        src_hresp,
  input  logic [N_PORTS*W_ADDR-1:0] src_haddr,
  input  logic [N_PORTS-1:0]        src_hwrite,
  input  logic [N_PORTS*2-1:0]      src_htrans,
  input  logic [N_PORTS*3-1:0]      src_hsize,
  input  logic [N_PORTS*3-1:0]      src_hburst,
  input  logic [N_PORTS*4-1:0]      src_hprot,
  input  logic [N_PORTS-1:0]        src_hmastlock,
  input  logic [N_PORTS*W_DATA-1:0] src_hwdata,
  output logic [N_PORTS*W_DATA-1:0] src_hrdata,
  input  logic [N_PORTS-1:0]        src_hexcl,
  input  logic [N_PORTS*8-1:0]      src_hmaster,
  output logic [N_PORTS-1:0]        src_hexokay,
  input  logic [N_PORTS*W_ADDR-1:0] src_d_pc,
  input  logic [N_PORTS*W_DATA-1:0] src_hartid,
  output logic                      dst_hready,
  input  logic                      dst_hready_resp,
  input  logic                      dst_hresp,
  input  logic                      dst_hexokay,
  output logic [W_ADDR-1:0]         dst_haddr,
  output logic                      dst_hwrite,
  output logic [1:0]                dst_htrans,
  output logic [2:0]                dst_hsize,
  output logic [2:0]                dst_hburst,
  output logic [3:0]                dst_hprot,
  output logic                      dst_hmastlock,
  output logic [W_DATA-1:0]         dst_hwdata,
  output logic                      dst_hexcl,
  output logic [7:0]                dst_hmaster,
  output logic [W_ADDR-1:0]         dst_d_pc,
  output logic [W_DATA-1:0]         dst_hartid,
  input  logic [W_DATA-1:0]         dst_hrdata
);

  // Flat address-phase layout: {hartid, d_pc, haddr, ap_ctrl_t}
  localparam int W_AP     = W_DATA + 2 * W_ADDR + AP_CTRL_W;
  localparam int ADDR_LSB = AP_CTRL_W;
  localparam int PC_LSB   = AP_CTRL_W + W_ADDR;
  localparam int HART_LSB = AP_CTRL_W + 2 * W_ADDR;

  logic [N_PORTS*W_AP-1:0] live_ap;
  logic [N_PORTS*W_AP-1:0] sel_ap;
  logic [N_PORTS*W_AP-1:0] buf_ap_q;
  logic [N_PORTS*W_AP-1:0] buf_ap_d;
  logic [N_PORTS-1:0]      buf_valid_q;
  logic [N_PORTS-1:0]      buf_valid_d;
  logic [N_PORTS-1:0]      gnt_d_q;
  logic [N_PORTS-1:0]      gnt_d_d;
  logic [N_PORTS-1:0]      lock_q;
  logic [N_PORTS-1:0]      lock_d;
  logic [N_PORTS-1:0]      live_req;
  logic [N_PORTS-1:0]      req;
  logic [N_PORTS-1:0]      grant;
  logic                    lock_active;
  logic [W_AP-1:0]         gnt_ap;
  logic [W_AP-1:0]         dst_ap;
  ap_ctrl_t                dst_ctrl;

  // Per-port request decode and buffer-vs-live source selection. A buffered
  // phase always takes precedence over whatever the stalled master drives.
  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    ap_ctrl_t live_ctrl;

    assign live_ctrl = '{
      hwrite:    src_hwrite[i],
      htrans:    src_htrans[2*i +: 2],
      hsize:     src_hsize[3*i +: 3],
      hburst:    src_hburst[3*i +: 3],
      hprot:     src_hprot[4*i +: 4],
      hmastlock: src_hmastlock[i],
      hexcl:     src_hexcl[i],
      hmaster:   src_hmaster[8*i +: 8]
    };

    assign live_ap[i*W_AP +: W_AP] = {src_hartid[i*W_DATA +: W_DATA],
                                      src_d_pc[i*W_ADDR +: W_ADDR],
                                      src_haddr[i*W_ADDR +: W_ADDR],
                                      live_ctrl};

    assign live_req[i] = src_hready[i] & src_htrans[2*i+1];
    assign req[i]      = buf_valid_q[i] | live_req[i];

    ahbl_arbiter_onehot_mux #(
      .N (2),
      .W (W_AP)
    ) u_src_mux (
      .sel      ({buf_valid_q[i], ~buf_valid_q[i]}),
      .data_in  ({buf_ap_q[i*W_AP +: W_AP], live_ap[i*W_AP +: W_AP]}),
      .data_out (sel_ap[i*W_AP +: W_AP])
    );
  end

  // Fixed-priority grant. A held lock only blocks others while the locked
  // port is still requesting; once it goes idle the bus is free again.
  always_comb begin
    grant       = '0;
    lock_active = |(lock_q & req);
    if (dst_hready_resp) begin
      if (lock_active) begin
        grant = lock_q;
      end else begin
        for (int i = N_PORTS - 1; i >= 0; i--) begin
          if (req[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
          end
        end
      end
    end
  end

  ahbl_arbiter_onehot_mux #(
    .N (N_PORTS),
    .W (W_AP)
  ) u_gnt_mux (
    .sel      (grant),
    .data_in  (sel_ap),
    .data_out (gnt_ap)
  );

  // With no grant the slave sees IDLE, other fields follow port 0 live.
  always_comb begin
    dst_ap = gnt_ap;
    if (grant == '0) begin
      dst_ap = live_ap[W_AP-1:0];
    end
    dst_ctrl = dst_ap[AP_CTRL_W-1:0];
    if (grant == '0) begin
      dst_ctrl.htrans = HTRANS_IDLE;
    end
  end

  assign dst_haddr     = dst_ap[ADDR_LSB +: W_ADDR];
  assign dst_d_pc      = dst_ap[PC_LSB +: W_ADDR];
  assign dst_hartid    = dst_ap[HART_LSB +: W_DATA];
  assign dst_hwrite    = dst_ctrl.hwrite;
  assign dst_htrans    = dst_ctrl.htrans;
  assign dst_hsize     = dst_ctrl.hsize;
  assign dst_hburst    = dst_ctrl.hburst;
  assign dst_hprot     = dst_ctrl.hprot;
  assign dst_hmastlock = dst_ctrl.hmastlock;
  assign dst_hexcl     = dst_ctrl.hexcl;
  assign dst_hmaster   = dst_ctrl.hmaster;
  assign dst_hready    = dst_hready_resp;

  // Capture any live request that is not issued this cycle; release a
  // buffer once it has been granted. When the slave stalls, grant is zero,
  // so every live request lands in its buffer.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_ap_d    = buf_ap_q;
    for (int i = 0; i < N_PORTS; i++) begin
      if (buf_valid_q[i]) begin
        if (grant[i]) begin
          buf_valid_d[i] = 1'b0;
        end
      end else if (live_req[i] && !grant[i]) begin
        buf_valid_d[i]            = 1'b1;
        buf_ap_d[i*W_AP +: W_AP] = live_ap[i*W_AP +: W_AP];
      end
    end
  end

  // Data-phase ownership and lock both advance only on accepted cycles.
  always_comb begin
    gnt_d_d = gnt_d_q;
    lock_d  = lock_q;
    if (dst_hready_resp) begin
      gnt_d_d = grant;
      lock_d  = ((grant != '0) && dst_ctrl.hmastlock) ? grant : '0;
    end
  end

  // Stall is built only from registered state and the slave's ready, so no
  // master's htrans can reach any hready_resp combinationally.
  always_comb begin
    src_hready_resp = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      src_hready_resp[i] = gnt_d_q[i] ? dst_hready_resp : ~buf_valid_q[i];
    end
  end

  assign src_hresp   = gnt_d_q & {N_PORTS{dst_hresp}};
  assign src_hexokay = gnt_d_q & {N_PORTS{dst_hexokay}};
  assign src_hrdata  = {N_PORTS{dst_hrdata}};

  ahbl_arbiter_onehot_mux #(
    .N (N_PORTS),
    .W (W_DATA)
  ) u_wdata_mux (
    .sel      (gnt_d_q),
    .data_in  (src_hwdata),
    .data_out (dst_hwdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q <= '0;
      buf_ap_q    <= '0;
      gnt_d_q     <= '0;
      lock_q      <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_ap_q    <= buf_ap_d;
      gnt_d_q     <= gnt_d_d;
      lock_q      <= lock_d;
    end
  end

endmodule

// File: doc/ahbl_arbiter.md
# ahbl_arbiter

AHB-lite N:1 arbiter: merges N_PORTS upstream masters onto one downstream slave port, the inverse of the 1:N splitter in the busfabric. Losing masters are stalled and their address phase is buffered and replayed. Fixed priority, lowest index wins. Exclusive-access and trace sidebands travel with the granted transfer.

## Interface
Parameters:
- N_PORTS, 2, number of upstream masters
- W_ADDR, 32, address width
- W_DATA, 32, data width

Ports (per-master signals packed, port i at slice i):
- clk  in  1  bus clock
- rst  in  1  asynchronous, active-high reset
- src_hready  in  N_PORTS  per-master hready; tie to src_hready_resp for true masters
- src_hready_resp  out  N_PORTS  per-master ready response
- src_hresp  out  N_PORTS  per-master error response
- src_haddr  in  N_PORTS*W_ADDR  address
- src_hwrite  in  N_PORTS  write
- src_htrans  in  N_PORTS*2  transfer type
- src_hsize  in  N_PORTS*3  size
- src_hburst  in  N_PORTS*3  burst
- src_hprot  in  N_PORTS*4  protection
- src_hmastlock  in  N_PORTS  locked transfer
- src_hwdata  in  N_PORTS*W_DATA  write data
- src_hrdata  out  N_PORTS*W_DATA  read data, broadcast
- src_hexcl  in  N_PORTS  exclusive request
- src_hmaster  in  N_PORTS*8  master ID
- src_hexokay  out  N_PORTS  exclusive okay
- src_d_pc  in  N_PORTS*W_ADDR  trace PC sideband
- src_hartid  in  N_PORTS*W_DATA  hart ID sideband
- dst_hready  out  1  equals dst_hready_resp
- dst_hready_resp, dst_hresp, dst_hexokay  in  1 each
- dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata, dst_hexcl, dst_hmaster, dst_d_pc, dst_hartid  out  single-port widths as above
- dst_hrdata  in  W_DATA

## Operation
- req[i] = buf_valid[i] | (src_hready[i] & src_htrans[i][1]).
- Arbitration only when dst_hready_resp=1. Grant = lowest-index req, unless lock held (below). Granted port drives dst address phase from its buffer if buf_valid, else live inputs. No grant: dst_htrans=IDLE, other address signals from port 0 live.
- Live request on a port that loses: capture haddr/hwrite/htrans/hsize/hburst/hprot/hmastlock/hexcl/hmaster/d_pc/hartid into buffer i, set buf_valid[i]. Cleared when that buffer is granted.
- Also buffer all live requests arriving when dst_hready_resp=0.
- gnt_d (one-hot, data-phase owner) <= grant when dst_hready_resp=1.
- dst_hwdata = src_hwdata of gnt_d (zero if none). src_hrdata broadcast.
- src_hready_resp[i]: dst_hready_resp if gnt_d[i]; else 0 if buf_valid[i] or buffered request granted this cycle; else 1.
- src_hresp[i], src_hexokay[i] = dst value gated by gnt_d[i]. Slave two-cycle error passes through unchanged.
- Lock: granting a transfer with hmastlock=1 sets lock to that port. Cleared when the port issues a non-locked transfer or IDLE. Other ports are not granted while locked.
- SEQ beats arbitrate like NONSEQ. No burst hold.

## Timing
- Reset: buf_valid=0, gnt_d=0, lock=0. src_hready_resp all 1, src_hresp 0, src_hexokay 0, dst_htrans IDLE, dst_hwdata 0.
- Uncontended: zero added latency; address combinationally forwarded.
- Losing master: one extra stall cycle minimum per higher-priority transfer ahead.
- No combinational path from any src_htrans to any src_hready_resp. Stall derives only from registered buf_valid/gnt_d and dst_hready_resp.
- Reset mid-transfer drops buffers and data-phase ownership immediately.

## Structure
- Shared package holds the HTRANS_IDLE/BUSY/NONSEQ/SEQ constants.
- Reuse onehot_mux for the hwdata mux and for the buffer/live address-field mux.
- Priority encoder stays inline.

## Test plan
- Single master: port 0 read at 0x2000_0000, slave returns 0xDEADBEEF with 0 waits -> dst sees NONSEQ same cycle; port 0 hrdata=0xDEADBEEF; hready_resp never low.
- Simultaneous NONSEQ from port 0 (0x100) and port 1 (0x200) -> dst issues 0x100, then 0x200 next cycle from buffer. Port 1 hready_resp low exactly 1 cycle; write data routed per gnt_d.
- Slave 2 wait states on port 0 while port 1 requests -> port 1 buffered. Issued on the cycle dst_hready_resp returns high; buffer fields unchanged.
- Slave error on port 1 transfer -> port 1 sees hresp=1 for 2 cycles with hready_resp 0 then 1; port 0 hresp stays 0.
- Port 1 locked sequence (hmastlock=1, 3 transfers) with port 0 requesting throughout -> all 3 port-1 transfers complete first; port 0 granted after port 1 issues IDLE.
- Exclusive: port 1 hexcl=1, hmaster=0x05, slave hexokay=1 -> dst_hexcl=1, dst_hmaster=0x05; src_hexokay[1]=1 in data phase only.
